// File: rtl/ui_map_writer.sv
// ui_map_writer: expands one POINT / RECT / CLEAR / FRAME command into a row-major stream
// of single-tile writes. Defining UI_WRITER_FRAME_EN turns op 3 into an outline-only FRAME.
module ui_map_writer #(
   parameter int COLS_LOG2 = 6,
   parameter int ROWS_LOG2 = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [COLS_LOG2-1:0]           cmd_x,
   input  logic [ROWS_LOG2-1:0]           cmd_y,
   input  logic [COLS_LOG2:0]             cmd_w,
   input  logic [ROWS_LOG2:0]             cmd_h,
   input  logic [1:0]                     cmd_val,
   output logic                           busy,
   output logic                           done,
   output logic                           we,
   output logic [COLS_LOG2+ROWS_LOG2-1:0] addr,
   output logic [1:0]                     din
);
   localparam int CW = COLS_LOG2 + 1;
   localparam int RW = ROWS_LOG2 + 1;
   localparam logic [CW-1:0] NCOLS = CW'(1) << COLS_LOG2;
   localparam logic [RW-1:0] NROWS = RW'(1) << ROWS_LOG2;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd2} state_t;

   state_t                         state_q, state_d;
   logic [COLS_LOG2-1:0]           col_q, col_d, x0_q, x0_d, xe_q, xe_d;
   logic [ROWS_LOG2-1:0]           row_q, row_d, ye_q, ye_d;
   logic [1:0]                     din_q, din_d;
   logic                           we_q, we_d, done_q, done_d;
   logic [COLS_LOG2+ROWS_LOG2-1:0] addr_q, addr_d;
`ifdef UI_WRITER_FRAME_EN
   logic                           frame_q, frame_d;
   logic [ROWS_LOG2-1:0]           y0_q, y0_d;

   function automatic logic on_edge(input logic [COLS_LOG2-1:0] c, input logic [COLS_LOG2-1:0] c0,
                                    input logic [COLS_LOG2-1:0] c1, input logic [ROWS_LOG2-1:0] r,
                                    input logic [ROWS_LOG2-1:0] r0, input logic [ROWS_LOG2-1:0] r1);
      return (c == c0) || (c == c1) || (r == r0) || (r == r1);
   endfunction
`endif

   logic [COLS_LOG2-1:0] sx_s, xe_s;
   logic [ROWS_LOG2-1:0] sy_s, ye_s;
   logic [CW-1:0]        ew_s, room_w_s;
   logic [RW-1:0]        eh_s, room_h_s;

   // Decode the command into a start cell and a clipped, inclusive end cell
   always_comb begin
      room_w_s = NCOLS - {1'b0, cmd_x};
      room_h_s = NROWS - {1'b0, cmd_y};
      case (cmd_op)
         2'd0: begin
            sx_s = cmd_x;
            sy_s = cmd_y;
            ew_s = CW'(1);
            eh_s = RW'(1);
         end
         2'd2: begin
            sx_s = {COLS_LOG2{1'b0}};
            sy_s = {ROWS_LOG2{1'b0}};
            ew_s = NCOLS;
            eh_s = NROWS;
         end
         default: begin
            sx_s = cmd_x;
            sy_s = cmd_y;
            ew_s = (cmd_w < room_w_s) ? cmd_w : room_w_s;
            eh_s = (cmd_h < room_h_s) ? cmd_h : room_h_s;
         end
      endcase
      // Sums are formed one bit wider so x+w reaching the map edge cannot overflow
      xe_s = COLS_LOG2'({1'b0, sx_s} + ew_s - CW'(1));
      ye_s = ROWS_LOG2'({1'b0, sy_s} + eh_s - RW'(1));
   end

   // Next-state and registered-output logic of the traversal FSM
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      x0_d    = x0_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      din_d   = din_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
`ifdef UI_WRITER_FRAME_EN
      frame_d = frame_q;
      y0_d    = y0_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               din_d = cmd_val;
               x0_d  = sx_s;
               xe_d  = xe_s;
               ye_d  = ye_s;
               col_d = sx_s;
               row_d = sy_s;
`ifdef UI_WRITER_FRAME_EN
               y0_d    = sy_s;
               frame_d = (cmd_op == 2'd3);
`endif
               if ((ew_s == {CW{1'b0}}) || (eh_s == {RW{1'b0}})) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  // The first cell is a corner, so it is written even in outline mode
                  state_d = S_WRITE;
                  addr_d  = {sx_s, sy_s};
                  we_d    = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if ((col_q == xe_q) && (row_q == ye_q)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               if (col_q == xe_q) begin
                  col_d = x0_q;
                  row_d = row_q + ROWS_LOG2'(1);
               end else begin
                  col_d = col_q + COLS_LOG2'(1);
                  row_d = row_q;
               end
               addr_d = {col_d, row_d};
`ifdef UI_WRITER_FRAME_EN
               we_d = !frame_q || on_edge(col_d, x0_q, xe_q, row_d, y0_q, ye_q);
`else
               we_d = 1'b1;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= {COLS_LOG2{1'b0}};
         row_q   <= {ROWS_LOG2{1'b0}};
         x0_q    <= {COLS_LOG2{1'b0}};
         xe_q    <= {COLS_LOG2{1'b0}};
         ye_q    <= {ROWS_LOG2{1'b0}};
         din_q   <= 2'd0;
         addr_q  <= {(COLS_LOG2+ROWS_LOG2){1'b0}};
         we_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef UI_WRITER_FRAME_EN
         frame_q <= 1'b0;
         y0_q    <= {ROWS_LOG2{1'b0}};
`endif
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x0_q    <= x0_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         din_q   <= din_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         done_q  <= done_d;
`ifdef UI_WRITER_FRAME_EN
         frame_q <= frame_d;
         y0_q    <= y0_d;
`endif
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign we        = we_q;
   assign addr      = addr_q;
   assign din       = din_q;
   assign done      = done_q;
endmodule
